opamp_share_sched: RTL
======================

OPAMP_SHARE_SCHED -- requirements
Module: opamp_share_sched

Interface
REQ-001 Parameters SHALL be: SETTLE_CYCLES, default 4, the number of cycles the shared op_amp is driven before its output is sampled (legal range 1..255).
REQ-002 SAT_THRESH SHALL be a parameter, default 12000, the magnitude above which a captured result is flagged as saturated.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  system clock, rising-edge active.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req  in  4  per-channel measurement request, held high until done for that channel.
REQ-007 ch_inv  in  64  four signed 16-bit inverting-input values; channel n occupies bits [16n+15:16n].
REQ-008 ch_noninv  in  64  four signed 16-bit non-inverting-input values, packed the same way as ch_inv.
REQ-009 oa_out  in  16  signed output of the shared op_amp (pin6).
REQ-010 oa_inv  out  16  signed drive to op_amp pin2.
REQ-011 oa_noninv  out  16  signed drive to op_amp pin3.
REQ-012 gnt  out  4  one-hot grant; all zero when no channel is being served.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse marking a completed measurement.
REQ-015 done_ch  out  2  index of the channel that completed; valid only while done is high.
REQ-016 result  out  16  signed captured op_amp output.
REQ-017 sat_pos  out  1  result > SAT_THRESH; valid only while done is high.
REQ-018 sat_neg  out  1  result < -SAT_THRESH; valid only while done is high.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, SETTLE, CAPTURE and REPORT.
REQ-020 In IDLE with req nonzero, the block SHALL grant round-robin, starting the search at the channel after the last granted one (channel 0 after reset), and go to SETTLE on the next edge.
REQ-021 In SETTLE, gnt SHALL be one-hot for the granted channel, and oa_inv/oa_noninv SHALL equal that channel's registered inputs.
REQ-022 Channel inputs SHALL be sampled once, at grant; later changes on ch_inv/ch_noninv SHALL NOT affect the measurement in progress.
REQ-023 SETTLE SHALL last exactly SETTLE_CYCLES cycles, timed by an 8-bit down-counter loaded at grant, then go to CAPTURE.
REQ-024 CAPTURE SHALL last one cycle: gnt stays high and result is loaded from oa_out at the end of the cycle.
REQ-025 REPORT SHALL last one cycle: done=1, gnt=0, done_ch, sat_pos and sat_neg valid; then return to IDLE.
REQ-026 Latency from the edge that samples req to the done pulse SHALL be SETTLE_CYCLES+2 cycles.
REQ-027 Two consecutive grants SHALL be separated by at least one IDLE cycle.
REQ-028 If the granted req drops during SETTLE or CAPTURE, the block SHALL abort to IDLE on the next edge: no done pulse, result unchanged, and the round-robin pointer still advances.
REQ-029 oa_inv and oa_noninv SHALL be 0 whenever gnt is 0.
REQ-030 result SHALL hold its value between captures.
REQ-031 Saturation compares SHALL be signed, 17-bit: equal to ±SAT_THRESH is not saturated.
REQ-032 Simultaneous requests SHALL be served one at a time, with no channel starved: each is served within 4 grants.

Reset
REQ-033 On rst: state=IDLE, gnt=0, busy=0, done=0, done_ch=0, result=0, sat_pos=sat_neg=0, oa_inv=oa_noninv=0, round-robin pointer=3 (so channel 0 has first priority), counter=0.
REQ-034 rst asserted mid-operation SHALL take effect on the next edge and suppress any pending done pulse.

Structure
REQ-035 A shared package opamp_pkg SHALL hold the state encoding, DATA_W=16, NUM_CH=4, and the defaults for SETTLE_CYCLES and SAT_THRESH.
REQ-036 Round-robin selection SHALL be a separate sub-module rr_arbiter4: 4-bit req and last-grant pointer in, one-hot grant and valid out, purely combinational.
REQ-037 The FSM, counter, capture registers and output muxing SHALL reside in opamp_share_sched.

Verification (bench instantiates op_amp at VCC=+15000, VEE=-15000)
REQ-038 Ch0 inv=0, noninv=500 -> done after SETTLE_CYCLES+2 cycles, done_ch=0, result in (12000,14000), sat_pos=1.
REQ-039 Ch2 inv=500, noninv=0 -> result in (-14000,-12000), sat_neg=1, sat_pos=0.
REQ-040 All four req high from reset, inv=noninv=200 -> done_ch sequence 0,1,2,3, each result in (-1000,1000), no saturation flags.
REQ-041 Ch1 req dropped in 2nd SETTLE cycle -> no done pulse, gnt=0 next cycle, next grant goes to ch2 if ch2 is requesting.
REQ-042 rst pulsed during CAPTURE -> next cycle all outputs at reset values, done never pulses.
REQ-043 Ch3 inputs changed mid-SETTLE from (100,110) to (110,100) -> result > 0, because inputs were sampled at grant.

Source files
------------

// File: rtl/opamp_pkg.sv
// -----------------------------------------------------------------------------
// opamp_pkg
// Shared definitions for the op-amp sharing scheduler: data widths, channel
// count, parameter defaults, FSM state encoding and a one-hot decode helper.
// -----------------------------------------------------------------------------
package opamp_pkg;

  localparam int DATA_W            = 16;
  localparam int NUM_CH            = 4;
  localparam int CH_W              = 2;
  localparam int SETTLE_CYCLES_DEF = 4;
  localparam int SAT_THRESH_DEF    = 12000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    REPORT  = 2'd3
  } state_t;

  // Index of the set bit in a one-hot channel vector (0 when none is set).
  function automatic logic [CH_W-1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (oh[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/opamp_share_sched_rr_arbiter4.sv
// -----------------------------------------------------------------------------
// rr_arbiter4
// Purely combinational 4-way round-robin arbiter. The search starts at the
// channel after 'last' and wraps, so the most recently served channel has the
// lowest priority.
//   req   in  4  request vector
//   last  in  2  index of the last granted channel
//   grant out 4  one-hot grant (zero when no request)
//   valid out 1  any request present
// -----------------------------------------------------------------------------
module rr_arbiter4
  import opamp_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last,
  output logic [NUM_CH-1:0] grant,
  output logic              valid
);

  always_comb begin
    logic [CH_W-1:0] idx;
    logic            found;
    // NOTE: every variable assigned in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = last + CH_W'(i);  // 2-bit add wraps modulo 4
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/opamp_share_sched.sv
// -----------------------------------------------------------------------------
// opamp_share_sched
// Time-multiplexes one op-amp between four measurement channels. A granted
// channel's inputs are registered, driven onto the op-amp for SETTLE_CYCLES
// cycles, the op-amp output is captured, and a one-cycle done pulse reports
// the result with signed saturation flags.
//   clk        in  1   rising-edge clock
//   rst        in  1   synchronous active-high reset
//   req        in  4   per-channel request, held until done for that channel
//   ch_inv     in  64  4 x signed 16-bit inverting inputs, ch n at [16n+:16]
//   ch_noninv  in  64  4 x signed 16-bit non-inverting inputs
//   oa_out     in  16  op-amp output
//   oa_inv     out 16  drive to op-amp inverting pin (0 when not granted)
//   oa_noninv  out 16  drive to op-amp non-inverting pin (0 when not granted)
//   gnt        out 4   one-hot grant during SETTLE and CAPTURE
//   busy       out 1   high outside IDLE
//   done       out 1   completion pulse
//   done_ch    out 2   completed channel, valid with done
//   result     out 16  last captured op-amp output
//   sat_pos    out 1   result > SAT_THRESH, valid with done
//   sat_neg    out 1   result < -SAT_THRESH, valid with done
// -----------------------------------------------------------------------------
module opamp_share_sched
  import opamp_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int SAT_THRESH    = SAT_THRESH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH*DATA_W-1:0] ch_inv,
  input  logic [NUM_CH*DATA_W-1:0] ch_noninv,
  input  logic [DATA_W-1:0]        oa_out,
  output logic [DATA_W-1:0]        oa_inv,
  output logic [DATA_W-1:0]        oa_noninv,
  output logic [NUM_CH-1:0]        gnt,
  output logic                     busy,
  output logic                     done,
  output logic [CH_W-1:0]          done_ch,
  output logic [DATA_W-1:0]        result,
  output logic                     sat_pos,
  output logic                     sat_neg
);

  localparam logic [7:0]         SETTLE_LOAD = 8'(SETTLE_CYCLES);
  localparam logic signed [16:0] SAT_P       = 17'(SAT_THRESH);
  localparam logic signed [16:0] SAT_N       = -SAT_P;

  state_t                    state, state_nxt;
  logic [CH_W-1:0]           ptr;       // last granted channel
  logic [CH_W-1:0]           sel;       // channel being served
  logic [7:0]                cnt;       // remaining SETTLE cycles
  logic [DATA_W-1:0]         inv_q, noninv_q, result_q;
  logic [NUM_CH-1:0]         arb_grant;
  logic                      arb_valid;
  logic [CH_W-1:0]           grant_idx;
  logic signed [16:0]        res_ext;

  rr_arbiter4 u_arb (
    .req   (req),
    .last  (ptr),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  assign grant_idx = onehot_to_idx(arb_grant);
  assign res_ext   = {result_q[DATA_W-1], result_q};
  assign result    = result_q;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath: grant bookkeeping, input sampling, settle timer, capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= CH_W'(NUM_CH - 1);  // channel 0 searched first
      sel      <= '0;
      cnt      <= '0;
      inv_q    <= '0;
      noninv_q <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            // Pointer moves at grant, so an aborted channel still loses its turn.
            sel      <= grant_idx;
            ptr      <= grant_idx;
            cnt      <= SETTLE_LOAD;
            inv_q    <= ch_inv[int'(grant_idx)*DATA_W +: DATA_W];
            noninv_q <= ch_noninv[int'(grant_idx)*DATA_W +: DATA_W];
          end
        end
        SETTLE: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
        end
        CAPTURE: begin
          if (req[sel]) result_q <= oa_out;
        end
        default: ;
      endcase
    end
  end

  // Next state and output decode.
  always_comb begin
    state_nxt = state;
    gnt       = '0;
    oa_inv    = '0;
    oa_noninv = '0;
    busy      = (state != IDLE);
    done      = 1'b0;
    done_ch   = '0;
    sat_pos   = 1'b0;
    sat_neg   = 1'b0;
    case (state)
      IDLE: begin
        if (arb_valid) state_nxt = SETTLE;
      end
      SETTLE: begin
        gnt       = NUM_CH'(1) << sel;
        oa_inv    = inv_q;
        oa_noninv = noninv_q;
        if (!req[sel])          state_nxt = IDLE;
        else if (cnt == 8'd1)   state_nxt = CAPTURE;
      end
      CAPTURE: begin
        gnt       = NUM_CH'(1) << sel;
        oa_inv    = inv_q;
        oa_noninv = noninv_q;
        state_nxt = req[sel] ? REPORT : IDLE;
      end
      REPORT: begin
        done      = 1'b1;
        done_ch   = sel;
        sat_pos   = (res_ext > SAT_P);
        sat_neg   = (res_ext < SAT_N);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
